// File: rtl/nand_model_check_seq_pkg.sv
// Shared definitions for the 2-input gate model checker.
// Contents: sequencer state encoding, reference truth tables indexed by
// {a,b} (bit0 = 00 ... bit3 = 11), vector width and a popcount helper.
package gate_chk_pkg;

  localparam int VEC_W = 2;

  localparam logic [3:0] NAND_TT = 4'b0111;
  localparam logic [3:0] AND_TT  = 4'b1000;
  localparam logic [3:0] OR_TT   = 4'b1110;
  localparam logic [3:0] NOR_TT  = 4'b0001;
  localparam logic [3:0] XOR_TT  = 4'b0110;
  localparam logic [3:0] XNOR_TT = 4'b1001;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    CHECK  = 2'd2,
    DONE   = 2'd3
  } state_e;

  // Number of set bits; callers zero-extend narrower masks to 32 bits.
  function automatic logic [5:0] popcount32(input logic [31:0] v);
    logic [5:0] c;
    c = '0;
    for (int i = 0; i < 32; i++) begin
      c = c + {5'd0, v[i]};
    end
    return c;
  endfunction

endpackage

// File: rtl/nand_model_check_seq_if.sv
// Bundle between the checker and the surrounding test environment.
// slave  : checker side (takes start/abort/dut_y, drives everything else)
// master : environment side (drives start/abort and the model outputs)
interface nand_model_check_seq_if #(
  parameter int NUM_MODELS = 3,
  parameter int CNT_W      = 4
);
  logic                          start;
  logic                          abort;
  logic                          dut_a;
  logic                          dut_b;
  logic [NUM_MODELS-1:0]         dut_y;
  logic                          busy;
  logic                          done;
  logic                          pass;
  logic [CNT_W-1:0]              err_count;
  logic [gate_chk_pkg::VEC_W-1:0] first_fail_vec;
  logic [NUM_MODELS-1:0]         first_fail_mask;

  modport master (
    output start, abort, dut_y,
    input  dut_a, dut_b, busy, done, pass, err_count, first_fail_vec, first_fail_mask
  );

  modport slave (
    input  start, abort, dut_y,
    output dut_a, dut_b, busy, done, pass, err_count, first_fail_vec, first_fail_mask
  );
endinterface

// File: rtl/nand_model_check_seq_gate_settle_timer.sv
// Settle-time down-counter for the gate checker.
// Ports: clk, rst (sync, active high), i_load / i_load_val load the count,
// i_en decrements towards zero, o_zero flags a count of zero.
module gate_settle_timer (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_load,
  input  logic       i_en,
  input  logic [7:0] i_load_val,
  output logic       o_zero
);
  logic [7:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_en && (r_cnt != 8'd0)) begin
      r_cnt <= r_cnt - 8'd1;
    end
  end

  assign o_zero = (r_cnt == 8'd0);
endmodule

// File: rtl/nand_model_check_seq.sv
// Self-checking sequencer for the parallel 2-input gate models.
// Walks {a,b} through 00,01,10,11, holds each for SETTLE_CYCLES, then compares
// every model output against TRUTH_TABLE and accumulates the result.
// Ports: clk, rst (sync, active high), bus (slave modport): start/abort
// control, dut_a/dut_b shared model inputs, dut_y model outputs,
// busy/done/pass status, err_count, first_fail_vec/first_fail_mask.
//
// state  | meaning
// IDLE   | waiting for start; outputs hold the last run's results
// SETTLE | vector driven, waiting for the models to settle
// CHECK  | compare model outputs for the current vector
// DONE   | one-cycle completion, done pulse
module nand_model_check_seq
  import gate_chk_pkg::*;
#(
  parameter logic [3:0] TRUTH_TABLE   = NAND_TT,
  parameter int         SETTLE_CYCLES = 2,
  parameter int         NUM_MODELS    = 3,
  parameter int         CNT_W         = 4
) (
  input logic                   clk,
  input logic                   rst,
  nand_model_check_seq_if.slave bus
);

  localparam logic [7:0] SETTLE_LD = 8'(SETTLE_CYCLES - 1);
  // Wide enough for the counter plus any popcount without wrapping.
  localparam int               SUM_W   = CNT_W + 7;
  localparam logic [SUM_W-1:0] ERR_MAX = SUM_W'({CNT_W{1'b1}});

  state_e                r_state;
  state_e                w_state_nxt;
  logic [VEC_W-1:0]      r_vec;
  logic [CNT_W-1:0]      r_err;
  logic [VEC_W-1:0]      r_ff_vec;
  logic [NUM_MODELS-1:0] r_ff_mask;
  logic                  r_fail_seen;
  logic                  r_pass;

  logic                  w_accept;
  logic                  w_load;
  logic                  w_check;
  logic                  w_tmr_en;
  logic                  w_tmr_zero;
  logic                  w_last_vec;
  logic [NUM_MODELS-1:0] w_mismatch;
  logic [SUM_W-1:0]      w_sum;
  logic [CNT_W-1:0]      w_err_nxt;

  gate_settle_timer u_timer (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_load),
    .i_en       (w_tmr_en),
    .i_load_val (SETTLE_LD),
    .o_zero     (w_tmr_zero)
  );

  assign w_last_vec = (r_vec == VEC_W'(3));
  assign w_mismatch = bus.dut_y ^ {NUM_MODELS{TRUTH_TABLE[r_vec]}};
  assign w_sum      = SUM_W'(r_err) + SUM_W'(popcount32(32'(w_mismatch)));
  assign w_err_nxt  = (w_sum > ERR_MAX) ? {CNT_W{1'b1}} : w_sum[CNT_W-1:0];

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_load      = 1'b0;
    w_check     = 1'b0;
    w_tmr_en    = 1'b0;
    case (r_state)
      IDLE: begin
        // abort has priority over a simultaneous start
        if (bus.start && !bus.abort) begin
          w_state_nxt = SETTLE;
          w_accept    = 1'b1;
          w_load      = 1'b1;
        end
      end
      SETTLE: begin
        if (bus.abort) begin
          w_state_nxt = IDLE;
        end else if (w_tmr_zero) begin
          w_state_nxt = CHECK;
        end else begin
          w_tmr_en = 1'b1;
        end
      end
      CHECK: begin
        if (bus.abort) begin
          w_state_nxt = IDLE;
        end else begin
          w_check = 1'b1;
          if (w_last_vec) begin
            w_state_nxt = DONE;
          end else begin
            w_state_nxt = SETTLE;
            w_load      = 1'b1;
          end
        end
      end
      DONE: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_vec       <= '0;
      r_err       <= '0;
      r_ff_vec    <= '0;
      r_ff_mask   <= '0;
      r_fail_seen <= 1'b0;
      r_pass      <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_vec       <= '0;
        r_err       <= '0;
        r_ff_vec    <= '0;
        r_ff_mask   <= '0;
        r_fail_seen <= 1'b0;
        r_pass      <= 1'b0;
      end
      if (w_check) begin
        r_err <= w_err_nxt;
        if ((w_mismatch != '0) && !r_fail_seen) begin
          r_ff_vec    <= r_vec;
          r_ff_mask   <= w_mismatch;
          r_fail_seen <= 1'b1;
        end
        if (w_last_vec) begin
          r_pass <= (w_err_nxt == '0);
        end else begin
          r_vec <= r_vec + VEC_W'(1);
        end
      end
      if ((r_state == DONE) && bus.abort) begin
        r_pass <= 1'b0;
      end
    end
  end

  // Abort during DONE suppresses the completion pulse in that same cycle.
  assign bus.done            = (r_state == DONE) && !bus.abort;
  assign bus.pass            = r_pass && !((r_state == DONE) && bus.abort);
  assign bus.busy            = (r_state == SETTLE) || (r_state == CHECK);
  assign bus.dut_a           = r_vec[1];
  assign bus.dut_b           = r_vec[0];
  assign bus.err_count       = r_err;
  assign bus.first_fail_vec  = r_ff_vec;
  assign bus.first_fail_mask = r_ff_mask;

endmodule

// File: tb/tb_nand_model_check_seq.sv
module tb_nand_model_check_seq;
  import gate_chk_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  nand_model_check_seq_if #(.NUM_MODELS(3), .CNT_W(4)) bus  ();
  nand_model_check_seq_if #(.NUM_MODELS(3), .CNT_W(2)) bus2 ();

  // Model truth tables for the main DUT: bit0 gate, bit1 dataflow, bit2 behavioural.
  logic [3:0] tt0, tt1, tt2;
  logic [1:0] idx1;
  assign idx1     = {bus.dut_a, bus.dut_b};
  assign bus.dut_y = {tt2[idx1], tt1[idx1], tt0[idx1]};
  // Second DUT: every model inverted (NAND complemented is AND).
  assign bus2.dut_y = {3{bus2.dut_a & bus2.dut_b}};

  nand_model_check_seq u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  nand_model_check_seq #(.CNT_W(2), .SETTLE_CYCLES(1)) u_dut2 (
    .clk (clk),
    .rst (rst),
    .bus (bus2)
  );

  int n_checks = 0;
  int n_errs   = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errs++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [3:0] t0, t1, t2;
    int         e_err, e_vec, e_mask;
    logic       e_pass;
  } vec_t;

  task automatic run_one(input int id, input vec_t v);
    int cyc, done_cyc, seq_bad, busy_at_done, pass_at1;
    tt0 = v.t0; tt1 = v.t1; tt2 = v.t2;
    bus.start = 1'b1;
    cyc = 0; done_cyc = -1; seq_bad = 0; busy_at_done = -1; pass_at1 = -1;
    while (done_cyc < 0 && cyc < 40) begin
      tick();
      bus.start = 1'b0;
      cyc++;
      if (cyc == 1) pass_at1 = int'(bus.pass);
      if (bus.done) begin
        done_cyc     = cyc;
        busy_at_done = int'(bus.busy);
      end else if (cyc <= 12 && int'(idx1) != (cyc - 1) / 3) begin
        seq_bad++;
      end
    end
    chk($sformatf("r%0d_done_cycle", id), done_cyc, 13);
    chk($sformatf("r%0d_vec_seq", id), seq_bad, 0);
    chk($sformatf("r%0d_pass_clr", id), pass_at1, 0);
    chk($sformatf("r%0d_busy_at_done", id), busy_at_done, 0);
    chk($sformatf("r%0d_err_count", id), int'(bus.err_count), v.e_err);
    chk($sformatf("r%0d_ff_vec", id), int'(bus.first_fail_vec), v.e_vec);
    chk($sformatf("r%0d_ff_mask", id), int'(bus.first_fail_mask), v.e_mask);
    chk($sformatf("r%0d_pass", id), int'(bus.pass), int'(v.e_pass));
    tick();
    chk($sformatf("r%0d_done_width", id), int'(bus.done), 0);
    chk($sformatf("r%0d_pass_hold", id), int'(bus.pass), int'(v.e_pass));
  endtask

  vec_t vecs[6];
  vec_t good;

  initial begin
    int cyc, done_cyc, n_done;

    good = '{t0: 4'b0111, t1: 4'b0111, t2: 4'b0111, e_err: 0, e_vec: 0, e_mask: 0, e_pass: 1'b1};
    vecs[0] = good;
    // behavioural model is AND: wrong on all four vectors
    vecs[1] = '{t0: 4'b0111, t1: 4'b0111, t2: 4'b1000, e_err: 4, e_vec: 0, e_mask: 3'b100, e_pass: 1'b0};
    // gate wrong only at 10, dataflow wrong only at 11
    vecs[2] = '{t0: 4'b0011, t1: 4'b1111, t2: 4'b0111, e_err: 2, e_vec: 2, e_mask: 3'b001, e_pass: 1'b0};
    // all three wrong only at 01
    vecs[3] = '{t0: 4'b0101, t1: 4'b0101, t2: 4'b0101, e_err: 3, e_vec: 1, e_mask: 3'b111, e_pass: 1'b0};
    // gate is NOR (wrong at 01,10), behavioural is XOR (wrong at 00)
    vecs[4] = '{t0: 4'b0001, t1: 4'b0111, t2: 4'b0110, e_err: 3, e_vec: 0, e_mask: 3'b100, e_pass: 1'b0};
    // all inverted: 12 mismatches, below the 4-bit limit
    vecs[5] = '{t0: 4'b1000, t1: 4'b1000, t2: 4'b1000, e_err: 12, e_vec: 0, e_mask: 3'b111, e_pass: 1'b0};

    rst = 1'b1;
    bus.start = 1'b0; bus.abort = 1'b0;
    bus2.start = 1'b0; bus2.abort = 1'b0;
    tt0 = 4'b0111; tt1 = 4'b0111; tt2 = 4'b0111;
    repeat (3) tick();
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_pass", int'(bus.pass), 0);
    chk("rst_err", int'(bus.err_count), 0);
    chk("rst_ab", int'(idx1), 0);
    chk("rst_ff", int'({bus.first_fail_vec, bus.first_fail_mask}), 0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 6; i++) run_one(i, vecs[i]);
    run_one(6, good);

    // abort during SETTLE of vector 10 after two erroring vectors
    tt0 = 4'b0111; tt1 = 4'b0111; tt2 = 4'b1000;
    bus.start = 1'b1;
    tick(); bus.start = 1'b0;           // cycle 1
    repeat (6) tick();                  // cycle 7
    chk("ab_settle_busy_before", int'(bus.busy), 1);
    chk("ab_settle_vec_before", int'(idx1), 2);
    bus.abort = 1'b1;
    tick(); bus.abort = 1'b0;           // cycle 8
    chk("ab_settle_busy", int'(bus.busy), 0);
    chk("ab_settle_err", int'(bus.err_count), 2);
    chk("ab_settle_ff_vec", int'(bus.first_fail_vec), 0);
    chk("ab_settle_ff_mask", int'(bus.first_fail_mask), 4);
    chk("ab_settle_pass", int'(bus.pass), 0);
    chk("ab_settle_ab_hold", int'(idx1), 2);
    n_done = 0;
    repeat (15) begin
      tick();
      if (bus.done) n_done++;
    end
    chk("ab_settle_no_done", n_done, 0);
    run_one(7, good);

    // abort in CHECK of vector 00: comparison must be dropped
    tt2 = 4'b1000;
    bus.start = 1'b1;
    tick(); bus.start = 1'b0;           // cycle 1
    tick(); tick();                     // cycle 3 (CHECK)
    bus.abort = 1'b1;
    tick(); bus.abort = 1'b0;           // cycle 4
    chk("ab_check_busy", int'(bus.busy), 0);
    chk("ab_check_err", int'(bus.err_count), 0);
    chk("ab_check_ff_mask", int'(bus.first_fail_mask), 0);
    tick();

    // start while in DONE is ignored
    tt2 = 4'b0111;
    bus.start = 1'b1;
    tick(); bus.start = 1'b0;           // cycle 1
    repeat (12) tick();                 // cycle 13
    chk("done_start_done", int'(bus.done), 1);
    bus.start = 1'b1;
    tick(); bus.start = 1'b0;           // cycle 14
    chk("done_start_busy", int'(bus.busy), 0);
    tick();
    chk("done_start_busy2", int'(bus.busy), 0);
    chk("done_start_pass", int'(bus.pass), 1);

    // mid-run start ignored, then rst at cycle 6
    tt2 = 4'b1000;
    bus.start = 1'b1;
    tick(); bus.start = 1'b0;           // cycle 1
    repeat (3) tick();                  // cycle 4
    bus.start = 1'b1;
    tick(); bus.start = 1'b0;           // cycle 5
    chk("midstart_vec", int'(idx1), 1);
    chk("midstart_busy", int'(bus.busy), 1);
    tick();                             // cycle 6
    chk("midstart_err", int'(bus.err_count), 1);
    rst = 1'b1;
    tick(); rst = 1'b0;                 // cycle 7
    chk("midrst_busy", int'(bus.busy), 0);
    chk("midrst_err", int'(bus.err_count), 0);
    chk("midrst_ab", int'(idx1), 0);
    chk("midrst_ff", int'({bus.first_fail_vec, bus.first_fail_mask}), 0);
    chk("midrst_done_pass", int'({bus.done, bus.pass}), 0);
    tick(); tick();
    chk("midrst_idle", int'(bus.busy), 0);

    // start together with abort in IDLE is not accepted
    bus.start = 1'b1; bus.abort = 1'b1;
    tick(); bus.start = 1'b0; bus.abort = 1'b0;
    chk("start_abort_busy", int'(bus.busy), 0);
    tick();
    chk("start_abort_busy2", int'(bus.busy), 0);

    // CNT_W=2, SETTLE_CYCLES=1, all models inverted
    bus2.start = 1'b1;
    cyc = 0; done_cyc = -1;
    while (done_cyc < 0 && cyc < 40) begin
      tick();
      bus2.start = 1'b0;
      cyc++;
      if (bus2.done) done_cyc = cyc;
    end
    chk("sat_done_cycle", done_cyc, 9);
    chk("sat_err", int'(bus2.err_count), 3);
    chk("sat_ff_vec", int'(bus2.first_fail_vec), 0);
    chk("sat_ff_mask", int'(bus2.first_fail_mask), 7);
    chk("sat_pass", int'(bus2.pass), 0);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
